// File: rtl/dct_transpose.sv
// dct_transpose: ping-pong 8x8 transpose buffer between 1-D DCT passes.
// Define DCT_TRANSPOSE_STAT_EN to add the blk_cnt_o completed-block counter.
module dct_transpose #(
    parameter int DW = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [0:7][DW-1:0] in_row_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [0:7][DW-1:0] out_col_o
`ifdef DCT_TRANSPOSE_STAT_EN
    ,
    output logic [15:0]        blk_cnt_o
`endif
);

    logic [0:7][DW-1:0] mem_q [2][8];
    logic [1:0]         full_q, full_d;
    logic               wb_q, wb_d;
    logic               rb_q, rb_d;
    logic [2:0]         wr_q, wr_d;
    logic [2:0]         rc_q, rc_d;
    logic               wr_en, rd_en;

    assign in_ready_o  = !full_q[wb_q];
    assign out_valid_o = full_q[rb_q];
    assign wr_en       = in_valid_i && in_ready_o;
    assign rd_en       = out_valid_o && out_ready_i;

    // A write needs full[wb]=0 and a read needs full[rb]=1, so the
    // two can never touch the same flag in one cycle.
    always_comb begin
        full_d = full_q;
        wb_d   = wb_q;
        wr_d   = wr_q;
        rb_d   = rb_q;
        rc_d   = rc_q;
        if (wr_en) begin
            wr_d = wr_q + 3'd1;
            if (wr_q == 3'd7) begin
                full_d[wb_q] = 1'b1;
                wb_d         = !wb_q;
            end
        end
        if (rd_en) begin
            rc_d = rc_q + 3'd1;
            if (rc_q == 3'd7) begin
                full_d[rb_q] = 1'b0;
                rb_d         = !rb_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 2'b00;
            wb_q   <= 1'b0;
            wr_q   <= 3'd0;
            rb_q   <= 1'b0;
            rc_q   <= 3'd0;
        end else begin
            full_q <= full_d;
            wb_q   <= wb_d;
            wr_q   <= wr_d;
            rb_q   <= rb_d;
            rc_q   <= rc_d;
        end
    end

    // Bank storage carries no reset; stale contents are never exposed
    // because out_valid_o depends only on the full flags.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wb_q][wr_q] <= in_row_i;
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_col
        assign out_col_o[i] = mem_q[rb_q][i][rc_q];
    end

`ifdef DCT_TRANSPOSE_STAT_EN
    logic [15:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (rd_en && rc_q == 3'd7) begin
            blk_cnt_d = blk_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blk_cnt_q <= 16'd0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign blk_cnt_o = blk_cnt_q;
`endif

endmodule

// File: tb/tb_dct_transpose.sv
// tb_dct_transpose: directed checks of the ping-pong transpose buffer.
// Define DCT_TRANSPOSE_STAT_EN to also check blk_cnt_o.
module tb_dct_transpose;

    logic              clk_i;
    logic              rst_ni;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [0:7][15:0]  in_row_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [0:7][15:0]  out_col_o;
`ifdef DCT_TRANSPOSE_STAT_EN
    logic [15:0]       blk_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    dct_transpose #(.DW(16)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_row_i    (in_row_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_col_o   (out_col_o)
`ifdef DCT_TRANSPOSE_STAT_EN
        ,
        .blk_cnt_o   (blk_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // mode 3 uses the signed extremes, other modes a counting pattern
    function automatic logic [15:0] val(input logic [15:0] seed,
                                        input int b, input int r,
                                        input int c, input int mode);
        if (mode == 3)
            return (((r ^ c ^ b) & 1) != 0) ? 16'h7FFF : 16'h8000;
        return seed + 16'(b * 256 + r * 16 + c);
    endfunction

    function automatic logic [0:7][15:0] mkrow(input logic [15:0] seed,
                                               input int b, input int r,
                                               input int mode);
        logic [0:7][15:0] row;
        for (int c = 0; c < 8; c++) row[c] = val(seed, b, r, c, mode);
        return row;
    endfunction

    function automatic logic [0:7][15:0] mkcol(input logic [15:0] seed,
                                               input int b, input int c,
                                               input int mode);
        logic [0:7][15:0] col;
        for (int i = 0; i < 8; i++) col[i] = val(seed, b, i, c, mode);
        return col;
    endfunction

    task automatic do_reset();
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        in_row_i    = '0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst in_ready", 128'(in_ready_o), 128'(1'b1));
        chk("rst out_valid", 128'(out_valid_o), 128'(1'b0));
`ifdef DCT_TRANSPOSE_STAT_EN
        chk("rst blk_cnt", 128'(blk_cnt_o), 128'(16'd0));
`endif
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    // mode 0: ready=1, 1: ready held low 30 cycles, 2: stall at col 3
    task automatic run(input string tag, input int nblk, input int mode,
                       input logic [15:0] seed);
        int rs, cg, cyc, acc8, fov, stall, blocked;
        rs = 0; cg = 0; cyc = 0; acc8 = -1; fov = -1;
        stall = 2; blocked = 0;
        while (cg < 8 * nblk && cyc < 300) begin
            in_valid_i = (rs < 8 * nblk);
            in_row_i   = mkrow(seed, rs / 8, rs % 8, mode);
            out_ready_i = 1'b1;
            if (mode == 1 && cyc < 30) out_ready_i = 1'b0;
            if (mode == 2 && cg == 3 && stall > 0) begin
                out_ready_i = 1'b0;
                stall--;
            end
            @(negedge clk_i);
            if (out_valid_o && fov < 0) fov = cyc;
            if (in_valid_i && !in_ready_o) blocked++;
            if (out_valid_o)
                chk({tag, " col"}, out_col_o,
                    mkcol(seed, cg / 8, cg % 8, mode));
            if (out_valid_o && out_ready_i) cg++;
            if (mode == 1 && cyc == 29) begin
                chk({tag, " rows held"}, 128'(rs), 128'(16));
                chk({tag, " in_ready low"}, 128'(in_ready_o), 128'(1'b0));
            end
            if (in_valid_i && in_ready_o) begin
                rs++;
                if (rs == 8) acc8 = cyc;
            end
            @(posedge clk_i);
            #1;
            cyc++;
        end
        in_valid_i = 1'b0;
        chk({tag, " cols done"}, 128'(cg), 128'(8 * nblk));
        chk({tag, " latency"}, 128'(fov - acc8), 128'(1));
        if (mode == 0)
            chk({tag, " no in stall"}, 128'(blocked), 128'(0));
        if (mode == 2)
            chk({tag, " stall used"}, 128'(stall), 128'(0));
    endtask

    initial begin
        do_reset();
        run("basic", 1, 0, 16'h0000);

        do_reset();
        run("stream", 4, 0, 16'h0300);
`ifdef DCT_TRANSPOSE_STAT_EN
        chk("stream blk_cnt", 128'(blk_cnt_o), 128'(16'd4));
`endif

        do_reset();
        run("bp", 3, 1, 16'h4000);

        do_reset();
        run("stall", 1, 2, 16'h5000);

        do_reset();
        for (int r = 0; r < 5; r++) begin
            in_valid_i  = 1'b1;
            out_ready_i = 1'b1;
            in_row_i    = mkrow(16'h1000, 0, r, 0);
            @(posedge clk_i);
            #1;
        end
        in_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst out_valid", 128'(out_valid_o), 128'(1'b0));
        chk("midrst in_ready", 128'(in_ready_o), 128'(1'b1));
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("postrst out_valid", 128'(out_valid_o), 128'(1'b0));
        @(posedge clk_i);
        #1;
        run("fresh", 1, 0, 16'h2000);

        do_reset();
        run("extreme", 2, 3, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
